// File: rtl/alu_share_arbiter_if.sv
// Request, ALU and response signals of the shared-ALU arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int FUN_W = 4,
  parameter int TAG_W = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [FUN_W-1:0] req0_fun;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [FUN_W-1:0] req1_fun;
  logic [TAG_W-1:0] req1_tag;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [FUN_W-1:0] alu_fun;
  logic [WIDTH-1:0] alu_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_src;
  logic             rsp_illegal;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_fun, req0_tag,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_fun, req1_tag,
    output req1_ready,
    output alu_a, alu_b, alu_fun,
    input  alu_result,
    output rsp_valid, rsp_result, rsp_tag, rsp_src, rsp_illegal,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_fun, req0_tag,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_fun, req1_tag,
    input  req1_ready,
    input  alu_a, alu_b, alu_fun,
    output alu_result,
    input  rsp_valid, rsp_result, rsp_tag, rsp_src, rsp_illegal,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters,
// with a single-entry response buffer that can drain and refill in one cycle.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int FUN_W = 4,
  parameter int TAG_W = 4
) (
  input logic                CLK,
  input logic                RST_N,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_result;
  logic [TAG_W-1:0] r_tag;
  logic             r_src;
  logic             r_illegal;
  logic             r_last_grant;

  logic             w_can_accept;
  logic             w_grant_vld;
  logic             w_grant_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_fun_legal;

  // The buffer may be refilled in the same cycle it is drained.
  assign w_can_accept = (r_state == EMPTY) || bus.rsp_ready;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_grant_vld = 1'b0;
    w_grant_idx = 1'b0;
    if (w_can_accept) begin
      if (bus.req0_valid && bus.req1_valid) begin
        w_grant_vld = 1'b1;
        w_grant_idx = ~r_last_grant;
      end else if (bus.req0_valid) begin
        w_grant_vld = 1'b1;
        w_grant_idx = 1'b0;
      end else if (bus.req1_valid) begin
        w_grant_vld = 1'b1;
        w_grant_idx = 1'b1;
      end
    end
  end

  assign bus.req0_ready = w_grant_vld && !w_grant_idx;
  assign bus.req1_ready = w_grant_vld &&  w_grant_idx;

  // Idle drive is an undefined function so the ALU output settles to zero.
  always_comb begin
    bus.alu_a   = '0;
    bus.alu_b   = '0;
    bus.alu_fun = '1;
    w_tag       = '0;
    if (w_grant_vld) begin
      if (w_grant_idx) begin
        bus.alu_a   = bus.req1_a;
        bus.alu_b   = bus.req1_b;
        bus.alu_fun = bus.req1_fun;
        w_tag       = bus.req1_tag;
      end else begin
        bus.alu_a   = bus.req0_a;
        bus.alu_b   = bus.req0_b;
        bus.alu_fun = bus.req0_fun;
        w_tag       = bus.req0_tag;
      end
    end
  end

  always_comb begin
    w_fun_legal = 1'b0;
    case (bus.alu_fun)
      4'b0000, 4'b1000, 4'b0110, 4'b0111, 4'b0100, 4'b0101,
      4'b0001, 4'b1101, 4'b0010, 4'b0011, 4'b1001: w_fun_legal = 1'b1;
      default:                                     w_fun_legal = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: all buffer fields are reset, so a response in flight is dropped and outputs read zero.
      r_state      <= EMPTY;
      r_result     <= '0;
      r_tag        <= '0;
      r_src        <= 1'b0;
      r_illegal    <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_grant_vld) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_state      <= FULL;
      r_result     <= bus.alu_result;
      r_tag        <= w_tag;
      r_src        <= w_grant_idx;
      r_illegal    <= ~w_fun_legal;
      r_last_grant <= w_grant_idx;
    end else if (bus.rsp_ready) begin
      r_state      <= EMPTY;
    end
  end

  assign bus.rsp_valid   = (r_state == FULL);
  assign bus.rsp_result  = r_result;
  assign bus.rsp_tag     = r_tag;
  assign bus.rsp_src     = r_src;
  assign bus.rsp_illegal = r_illegal;

  a_one_ready : assert property (@(posedge CLK) disable iff (!RST_N)
    !(bus.req0_ready && bus.req1_ready));

  a_stall_hold : assert property (@(posedge CLK) disable iff (!RST_N)
    (bus.rsp_valid && !bus.rsp_ready) |=> ($stable(bus.rsp_result) && bus.rsp_valid));

endmodule
